mem_march_tester: RTL and testbench

//  Parametrised memory-system tester: drives an external 1W/1R memory through up to four

---
 rtl/mem_march_tester_if.sv | 15 +
 rtl/mem_march_tester.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_march_tester.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_march_tester_if.sv
// Memory-side bus of the march tester: one write port and one read port.
// The tester drives the master side and the memory model or array drives the slave side.
interface mem_march_tester_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          we;
    logic [AW-1:0] wra;
    logic [DW-1:0] wrd;
    logic [AW-1:0] rda;
    logic [DW-1:0] rdd;

    modport master (output we, output wra, output wrd, output rda, input rdd);
    modport slave  (input we, input wra, input wrd, input rda, output rdd);
endinterface

// File: rtl/mem_march_tester.sv
// Write-read-verify tester that sweeps every address with up to four data patterns.
// It keeps per-test attempt and fail counts and records the first failing location.
module mem_march_tester #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1,
    parameter int CW     = AW + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 enable,
    input  logic [3:0]           test_mask,
    mem_march_tester_if.master   mem,
    output logic                 busy,
    output logic                 done,
    output logic [4*CW-1:0]      attempts,
    output logic [4*CW-1:0]      fails,
    output logic                 ff_valid,
    output logic [1:0]           ff_test,
    output logic [AW-1:0]        ff_addr,
    output logic [DW-1:0]        ff_exp,
    output logic [DW-1:0]        ff_got
);

    localparam int             WCW       = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [AW-1:0]  ADDR_MAX  = {AW{1'b1}};
    localparam logic [AW-1:0]  ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0]  ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  ONE_CW    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WCW-1:0] WAIT_INIT = WCW'(RD_LAT > 2 ? RD_LAT - 2 : 0);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        WAIT = 3'd3,
        VFY  = 3'd4,
        DONE = 3'd5
    } state_t;

    // Data pattern of test t at address a.
    function automatic logic [DW-1:0] pattern(input logic [1:0] t, input logic [AW-1:0] a);
        logic [DW-1:0]    p;
        logic [AW+DW-1:0] ext;
        p   = {DW{1'b0}};
        ext = {{DW{1'b0}}, a};
        case (t)
            2'd0: p = {DW{1'b0}};
            2'd1: p = {DW{1'b1}};
            2'd2: begin
                for (int i = 0; i < DW; i++) begin
                    p[i] = (((i % 2) == 0) && (i < 2 * (DW / 2))) ? ~a[0] : a[0];
                end
            end
            2'd3: p = ext[DW-1:0];
            default: p = {DW{1'b0}};
        endcase
        return p;
    endfunction

    // Lowest set mask bit at or above lo; bit 2 of the result flags that one was found.
    function automatic logic [2:0] first_test(input logic [3:0] m, input logic [2:0] lo);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i >= int'(lo))) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    state_t          state_r;
    logic [AW-1:0]   addr_r;
    logic [1:0]      test_r;
    logic [3:0]      mask_r;
    logic [WCW-1:0]  wait_cnt_r;
    logic            we_r;
    logic [DW-1:0]   wrd_r;
    logic            busy_r;
    logic            done_r;
    logic [4*CW-1:0] attempts_r;
    logic [4*CW-1:0] fails_r;
    logic            ff_valid_r;
    logic [1:0]      ff_test_r;
    logic [AW-1:0]   ff_addr_r;
    logic [DW-1:0]   ff_exp_r;
    logic [DW-1:0]   ff_got_r;

    logic [2:0]      start_sel_s;
    logic [2:0]      next_sel_s;
    logic [DW-1:0]   exp_s;
    logic            mismatch_s;
    logic [AW-1:0]   addr_inc_s;
    logic [DW-1:0]   next_pat_s;
    logic [DW-1:0]   wrap_pat_s;
    logic [DW-1:0]   start_pat_s;

    // Test selection, expected data and the write data of whichever WR comes next.
    always_comb begin
        start_sel_s = first_test(test_mask, 3'd0);
        next_sel_s  = first_test(mask_r, {1'b0, test_r} + 3'd1);
        exp_s       = pattern(test_r, addr_r);
        mismatch_s  = (mem.rdd != exp_s);
        addr_inc_s  = addr_r + ADDR_ONE;
        next_pat_s  = pattern(test_r, addr_inc_s);
        wrap_pat_s  = pattern(next_sel_s[1:0], ADDR_ZERO);
        start_pat_s = pattern(start_sel_s[1:0], ADDR_ZERO);
    end

    // Main sequencer; a low enable freezes every register so WR and WAIT simply stretch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            addr_r     <= ADDR_ZERO;
            test_r     <= 2'd0;
            mask_r     <= 4'd0;
            wait_cnt_r <= {WCW{1'b0}};
            we_r       <= 1'b0;
            wrd_r      <= {DW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            attempts_r <= {(4*CW){1'b0}};
            fails_r    <= {(4*CW){1'b0}};
            ff_valid_r <= 1'b0;
            ff_test_r  <= 2'd0;
            ff_addr_r  <= ADDR_ZERO;
            ff_exp_r   <= {DW{1'b0}};
            ff_got_r   <= {DW{1'b0}};
        end else if (enable) begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        mask_r     <= test_mask;
                        addr_r     <= ADDR_ZERO;
                        attempts_r <= {(4*CW){1'b0}};
                        fails_r    <= {(4*CW){1'b0}};
                        ff_valid_r <= 1'b0;
                        ff_test_r  <= 2'd0;
                        ff_addr_r  <= ADDR_ZERO;
                        ff_exp_r   <= {DW{1'b0}};
                        ff_got_r   <= {DW{1'b0}};
                        if (start_sel_s[2]) begin
                            state_r <= WR;
                            test_r  <= start_sel_s[1:0];
                            wrd_r   <= start_pat_s;
                            we_r    <= 1'b1;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end else begin
                            state_r <= DONE;
                            test_r  <= 2'd0;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                WR: begin
                    we_r    <= 1'b0;
                    state_r <= RD;
                end
                RD: begin
                    if (RD_LAT == 1) begin
                        state_r <= VFY;
                    end else begin
                        wait_cnt_r <= WAIT_INIT;
                        state_r    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_r == {WCW{1'b0}}) begin
                        state_r <= VFY;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - {{(WCW-1){1'b0}}, 1'b1};
                    end
                end
                VFY: begin
                    attempts_r[int'(test_r)*CW +: CW] <= attempts_r[int'(test_r)*CW +: CW] + ONE_CW;
                    if (mismatch_s) begin
                        fails_r[int'(test_r)*CW +: CW] <= fails_r[int'(test_r)*CW +: CW] + ONE_CW;
                        if (!ff_valid_r) begin
                            ff_valid_r <= 1'b1;
                            ff_test_r  <= test_r;
                            ff_addr_r  <= addr_r;
                            ff_exp_r   <= exp_s;
                            ff_got_r   <= mem.rdd;
                        end
                    end
                    if (addr_r != ADDR_MAX) begin
                        addr_r  <= addr_inc_s;
                        wrd_r   <= next_pat_s;
                        we_r    <= 1'b1;
                        state_r <= WR;
                    end else if (next_sel_s[2]) begin
                        addr_r  <= ADDR_ZERO;
                        test_r  <= next_sel_s[1:0];
                        wrd_r   <= wrap_pat_s;
                        we_r    <= 1'b1;
                        state_r <= WR;
                    end else begin
                        addr_r  <= ADDR_ZERO;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    we_r    <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // A paused WR must not write, so the write strobe is gated by enable directly.
    assign mem.we   = we_r & enable;
    assign mem.wra  = addr_r;
    assign mem.rda  = addr_r;
    assign mem.wrd  = wrd_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign attempts = attempts_r;
    assign fails    = fails_r;
    assign ff_valid = ff_valid_r;
    assign ff_test  = ff_test_r;
    assign ff_addr  = ff_addr_r;
    assign ff_exp   = ff_exp_r;
    assign ff_got   = ff_got_r;

endmodule

// File: tb/tb_mem_march_tester.sv
// Directed bench: RD_LAT=1 tester on an ideal memory with an optional stuck bit,
// and an RD_LAT=3 tester on a memory whose data is correct only exactly 3 cycles after each RD.
module tb_mem_march_tester;

    logic        clock;
    logic        reset;
    logic        start1, start2;
    logic        enable;
    logic [3:0]  mask1, mask2;
    logic        fault_en;

    logic        busy1, done1, ffv1, busy2, done2, ffv2;
    logic [19:0] att1, fail1, att2, fail2;
    logic [1:0]  fft1, fft2;
    logic [3:0]  ffa1, ffa2;
    logic [7:0]  ffe1, ffg1, ffe2, ffg2;

    int tests_run    = 0;
    int tests_failed = 0;
    int n;
    int t3_ok, wr_bad;
    logic mon_en;

    mem_march_tester_if #(.AW(4), .DW(8)) m1 ();
    mem_march_tester_if #(.AW(4), .DW(8)) m2 ();

    mem_march_tester #(.AW(4), .DW(8), .RD_LAT(1)) u1 (
        .clock(clock), .reset(reset), .start(start1), .enable(enable), .test_mask(mask1),
        .mem(m1.master), .busy(busy1), .done(done1), .attempts(att1), .fails(fail1),
        .ff_valid(ffv1), .ff_test(fft1), .ff_addr(ffa1), .ff_exp(ffe1), .ff_got(ffg1)
    );

    mem_march_tester #(.AW(4), .DW(8), .RD_LAT(3)) u2 (
        .clock(clock), .reset(reset), .start(start2), .enable(1'b1), .test_mask(mask2),
        .mem(m2.master), .busy(busy2), .done(done2), .attempts(att2), .fails(fail2),
        .ff_valid(ffv2), .ff_test(fft2), .ff_addr(ffa2), .ff_exp(ffe2), .ff_got(ffg2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Ideal one-cycle memory; bit 3 of address 5 can be forced high.
    logic [7:0] mem1 [16];
    always @(posedge clock) begin
        if (m1.we) mem1[m1.wra] <= m1.wrd;
        m1.rdd <= mem1[m1.rda] | ((fault_en && (m1.rda == 4'd5)) ? 8'h08 : 8'h00);
    end

    // Three-stage memory: rdd is inverted unless exactly 3 cycles after a read cycle.
    logic [7:0] mem2 [16];
    logic [7:0] d2 [3];
    logic       v2 [3];
    logic       prev_we2;
    always @(posedge clock) begin
        prev_we2 <= m2.we;
        if (m2.we) mem2[m2.wra] <= m2.wrd;
        d2[0] <= mem2[m2.rda];
        v2[0] <= prev_we2;
        d2[1] <= d2[0];
        v2[1] <= v2[0];
        d2[2] <= d2[1];
        v2[2] <= v2[1];
    end
    assign m2.rdd = v2[2] ? d2[2] : ~d2[2];

    // Write monitor for the T1/T3 run: every non-all-ones write must carry its address.
    always @(negedge clock) begin
        if (mon_en && m1.we) begin
            if (m1.wrd == 8'hFF) begin
            end else if (m1.wrd == {4'h0, m1.wra}) t3_ok <= t3_ok + 1;
            else wr_bad <= wr_bad + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse1(input logic [3:0] m);
        mask1  = m;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
    endtask

    task automatic wait_done1(input int max);
        while (!done1 && n < max) begin
            step();
            n++;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem1[i] = 8'h00;
            mem2[i] = 8'h00;
        end
        for (int i = 0; i < 3; i++) begin
            d2[i] = 8'h00;
            v2[i] = 1'b0;
        end
        prev_we2 = 1'b0;
        t3_ok = 0; wr_bad = 0; mon_en = 1'b0;
        reset = 1'b1; start1 = 1'b0; start2 = 1'b0; enable = 1'b1;
        mask1 = 4'd0; mask2 = 4'd0; fault_en = 1'b0;
        step(); step();
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_att", att1, 20'd0);
        check("rst_ffv", ffv1, 1'b0);
        check("rst_we", m1.we, 1'b0);
        reset = 1'b0;
        step();

        // All four tests on good memory
        pulse1(4'b1111);
        check("all_busy", busy1, 1'b1);
        n = 0; wait_done1(400);
        check("all_cycles", n, 192);
        check("all_att", att1, {5'd16, 5'd16, 5'd16, 5'd16});
        check("all_fails", fail1, 20'd0);
        check("all_ffv", ffv1, 1'b0);
        check("all_busy_end", busy1, 1'b0);

        // Stuck-at-1 on bit 3 of address 5, T0 only
        fault_en = 1'b1;
        pulse1(4'b0001);
        n = 0; wait_done1(200);
        fault_en = 1'b0;
        check("flt_cycles", n, 48);
        check("flt_att", att1, {15'd0, 5'd16});
        check("flt_fails", fail1, {15'd0, 5'd1});
        check("flt_ffv", ffv1, 1'b1);
        check("flt_test", fft1, 2'd0);
        check("flt_addr", ffa1, 4'd5);
        check("flt_exp", ffe1, 8'h00);
        check("flt_got", ffg1, 8'h08);

        // T1 then T3 only
        t3_ok = 0; wr_bad = 0; mon_en = 1'b1;
        pulse1(4'b1010);
        n = 0; wait_done1(200);
        mon_en = 1'b0;
        check("m1010_cycles", n, 96);
        check("m1010_att", att1, {5'd16, 5'd0, 5'd16, 5'd0});
        check("m1010_fails", fail1, 20'd0);
        check("t3_wrd_eq_wra", t3_ok, 16);
        check("t3_wr_bad", wr_bad, 0);

        // Pause for 10 cycles during a T2 WR, then a start pulse while busy
        pulse1(4'b1111);
        n = 0;
        repeat (99) begin step(); n++; end
        enable = 1'b0;
        #1;
        check("pause_we", m1.we, 1'b0);
        check("pause_wra", m1.wra, 4'd1);
        repeat (10) begin step(); n++; end
        enable = 1'b1;
        #1;
        check("resume_we", m1.we, 1'b1);
        check("resume_wrd", m1.wrd, 8'hAA);
        start1 = 1'b1;
        step(); n++;
        start1 = 1'b0;
        check("ign_start_busy", busy1, 1'b1);
        wait_done1(400);
        check("pause_cycles", n, 202);
        check("pause_att", att1, {5'd16, 5'd16, 5'd16, 5'd16});
        check("pause_fails", fail1, 20'd0);

        // Asynchronous reset partway through T1
        pulse1(4'b1111);
        repeat (60) step();
        #3 reset = 1'b1;
        #1;
        check("arst_busy", busy1, 1'b0);
        check("arst_att", att1, 20'd0);
        check("arst_we", m1.we, 1'b0);
        check("arst_wra", m1.wra, 4'd0);
        step();
        reset = 1'b0;
        step();

        // Empty mask: done right after the accepting edge
        pulse1(4'b0000);
        check("m0_done", done1, 1'b1);
        check("m0_busy", busy1, 1'b0);
        check("m0_att", att1, 20'd0);

        // Clean run after the reset
        pulse1(4'b0001);
        n = 0; wait_done1(200);
        check("clean_cycles", n, 48);
        check("clean_att", att1, {15'd0, 5'd16});
        check("clean_fails", fail1, 20'd0);

        // RD_LAT=3, T2 only
        mask2  = 4'b0100;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 300) begin step(); n++; end
        check("lat3_cycles", n, 80);
        check("lat3_att", att2, {5'd0, 5'd16, 10'd0});
        check("lat3_fails", fail2, 20'd0);
        check("lat3_ffv", ffv2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
